bitstream_decoder: RTL

- Converts a unipolar stochastic bitstream from the bitstream network back to a binary count by counting ones over a fixed window of 2**WINDOW_BITS valid samples.
- Acts as the reader for the network's bitstream outputs and is the counterpart to the stream generators that encode the integer inputs.
- Feeds a registered valid/ready result to the board-level display and control logic.

---
 rtl/bitstream_pkg.sv | 16 +
 rtl/bitstream_window_counter.sv | 34 +++
 rtl/bitstream_decoder.sv | 96 +++++++++
 3 files changed

// File: rtl/bitstream_pkg.sv
// rtl/bitstream_pkg.sv - shared types, constants and helpers for the bitstream decoder
package bitstream_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } decoder_state_t;

    localparam int DEFAULT_WINDOW_BITS = 8;

    // Bipolar mapping 2*ones - 2**window_bits, returned as 32-bit two's complement
    function automatic logic [31:0] to_bipolar(input logic [31:0] ones, input int window_bits);
        return (ones << 1) - (32'd1 << window_bits);
    endfunction

endpackage

// File: rtl/bitstream_window_counter.sv
// rtl/bitstream_window_counter.sv - sample/ones counters with window-end strobe
module bitstream_window_counter #(
    parameter int WINDOW_BITS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   advance,
    input  logic                   bit_val,
    output logic                   window_end,
    output logic [WINDOW_BITS:0]   final_ones
);

    logic [WINDOW_BITS-1:0] sample_cnt;
    logic [WINDOW_BITS:0]   ones_cnt;

    assign window_end = advance && (sample_cnt == {WINDOW_BITS{1'b1}});
    assign final_ones = ones_cnt + (WINDOW_BITS+1)'(bit_val);

    // sample_cnt wraps to 0 by itself at the window end; ones_cnt must be cleared explicitly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
            ones_cnt   <= '0;
        end else if (clear) begin
            sample_cnt <= '0;
            ones_cnt   <= '0;
        end else if (advance) begin
            sample_cnt <= sample_cnt + WINDOW_BITS'(1);
            ones_cnt   <= window_end ? '0 : final_ones;
        end
    end

endmodule

// File: rtl/bitstream_decoder.sv
// rtl/bitstream_decoder.sv - stochastic bitstream to binary count decoder; DECODER_BIPOLAR_EN selects bipolar output
module bitstream_decoder
    import bitstream_pkg::*;
#(
    parameter int WINDOW_BITS = DEFAULT_WINDOW_BITS,
    localparam int OUT_W = WINDOW_BITS + 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [OUT_W-1:0] value_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun
);

    decoder_state_t       state, state_next;
    logic                 advance;
    logic                 window_end;
    logic                 load;
    logic [WINDOW_BITS:0] final_ones;
    logic [OUT_W-1:0]     value_next;

    assign advance = (state == COUNT) && bit_valid;
    // A start on the window-end edge aborts the window instead of loading it
    assign load    = window_end && !start;

    bitstream_window_counter #(
        .WINDOW_BITS(WINDOW_BITS)
    ) u_window_counter (
        .clk        (clk),
        .rst        (rst),
        .clear      (start),
        .advance    (advance),
        .bit_val    (bit_in),
        .window_end (window_end),
        .final_ones (final_ones)
    );

`ifdef DECODER_BIPOLAR_EN
    assign value_next = OUT_W'(to_bipolar(32'(final_ones), WINDOW_BITS));
`else
    assign value_next = OUT_W'(final_ones);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = COUNT;
            end
            COUNT: begin
                if (start)     state_next = COUNT;
                else if (load) state_next = continuous ? COUNT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == COUNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_out <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                value_out <= value_next;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (start) begin
                overrun <= 1'b0;
            end else if (load && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
